// File: rtl/adder_pipelined_pkg.sv
// adder_pipelined_pkg: op encodings and default geometry shared by the pipelined adder
package adder_pipelined_pkg;
  localparam int WIDTH_DEF = 24;
  localparam int CHUNK_DEF = 8;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_e;
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple adder built from full_adder cells
// Ports: a_i, b_i operands, c_i carry in; s_o sum, c_o carry out, cm_o carry into the MSB.
module adder_chunk
  import adder_pipelined_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             cm_o
);
  logic [CHUNK:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(s_o[i]), .c_o(c[i+1]));
  end
  assign c_o  = c[CHUNK];
  assign cm_o = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: 1-bit full-adder cell
// Ports: a_i, b_i, c_i in; s_o sum, c_o carry out.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/adder_pipelined.sv
// adder_pipelined: WIDTH-bit add/sub split into CHUNK-bit ripple stages with valid/ready flow control
// Ports: Clock, Reset (sync, active-high); InValid/InReady with A, B, Op, CarryIn in;
// OutValid/OutReady with SUM, CarryOut, Overflow, Zero, Negative out.
// Define ADDER_FLAGS_EN to compute the four flags; otherwise they are tied 0.
module adder_pipelined
  import adder_pipelined_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  input  logic             CarryIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] SUM,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Negative
);
  localparam int STAGES = WIDTH / CHUNK;
  op_e op;
  logic adv, c0;
  logic [WIDTH-1:0] bx;
  assign op = op_e'(Op);
  assign adv = !OutValid | OutReady;
  assign InReady = adv;
  assign bx = (op == OP_SUB || op == OP_SBB) ? ~B : B;
  assign c0 = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : CarryIn;
  // Stage k adds chunk k; au/bu hold operand bits from chunk k upward, s_q the finished low chunks.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    logic [WIDTH-LO-1:0] au, bu;
    logic [LO+CHUNK-1:0] s_d, s_q;
    logic [CHUNK-1:0] s;
    logic ci, vi, co, cm, v_q, unused_c;
    adder_chunk #(.CHUNK(CHUNK)) u_add (
      .a_i(au[CHUNK-1:0]), .b_i(bu[CHUNK-1:0]), .c_i(ci), .s_o(s), .c_o(co), .cm_o(cm)
    );
    // Only the last stage consumes cm, and only with flags enabled.
    assign unused_c = co ^ cm;
    if (k == 0) begin : g_in
      assign au  = A;
      assign bu  = bx;
      assign ci  = c0;
      assign vi  = InValid;
      assign s_d = s;
    end else begin : g_mid
      assign au  = g_st[k-1].g_up.a_q;
      assign bu  = g_st[k-1].g_up.b_q;
      assign ci  = g_st[k-1].g_up.c_q;
      assign vi  = g_st[k-1].v_q;
      assign s_d = {s, g_st[k-1].s_q};
    end
    always_ff @(posedge Clock)
      if (Reset) {v_q, s_q} <= '0;
      else if (adv) {v_q, s_q} <= {vi, s_d};
    if (k < STAGES - 1) begin : g_up
      logic [WIDTH-LO-CHUNK-1:0] a_q, b_q;
      logic c_q;
      always_ff @(posedge Clock)
        if (Reset) {a_q, b_q, c_q} <= '0;
        else if (adv) {a_q, b_q, c_q} <= {au[WIDTH-LO-1:CHUNK], bu[WIDTH-LO-1:CHUNK], co};
    end
`ifdef ADDER_FLAGS_EN
    logic z_in, z_q;
    if (k == 0) begin : g_z0
      assign z_in = 1'b1;
    end else begin : g_zk
      assign z_in = g_st[k-1].z_q;
    end
    always_ff @(posedge Clock)
      if (Reset) z_q <= 1'b0;
      else if (adv) z_q <= z_in & ~|s;
`endif
  end
  assign OutValid = g_st[STAGES-1].v_q;
  assign SUM = g_st[STAGES-1].s_q;
`ifdef ADDER_FLAGS_EN
  logic cf_q, ov_q;
  always_ff @(posedge Clock)
    if (Reset) {cf_q, ov_q} <= '0;
    else if (adv) {cf_q, ov_q} <= {g_st[STAGES-1].co, g_st[STAGES-1].co ^ g_st[STAGES-1].cm};
  assign CarryOut = cf_q;
  assign Overflow = ov_q;
  assign Zero = g_st[STAGES-1].z_q;
  assign Negative = SUM[WIDTH-1];
`else
  assign {CarryOut, Overflow, Zero, Negative} = 4'b0;
`endif
endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined: directed-vector scoreboard bench for adder_pipelined (WIDTH=24, CHUNK=8)
module tb_adder_pipelined;
  import adder_pipelined_pkg::*;
  typedef struct packed {
    op_e         op;
    logic [23:0] a;
    logic [23:0] b;
    logic        ci;
    logic [23:0] s;
    logic [3:0]  f;
  } vec_t;
  typedef struct {
    int i;
    int acc;
  } ent_t;
`ifdef ADDER_FLAGS_EN
  localparam logic [3:0] FM = 4'hF;
`else
  localparam logic [3:0] FM = 4'h0;
`endif
  logic clk = 1'b0, rst = 1'b1, InValid = 1'b0, CarryIn = 1'b0, OutReady = 1'b1;
  logic InReady, OutValid, CarryOut, Overflow, Zero, Negative;
  logic [1:0] Op = 2'b00;
  logic [23:0] A = '0, B = '0, SUM;
  int n_chk = 0, n_fail = 0, cyc = 0, cur = 0;
  bit nostall = 1'b1;
  ent_t q[$];
  // flags f = {CarryOut, Overflow, Zero, Negative}
  vec_t tbl [10] = '{
    '{OP_ADD, 24'h00FFFF, 24'h000001, 1'b0, 24'h010000, 4'b0000},
    '{OP_SUB, 24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 4'b0001},
    '{OP_ADD, 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 4'b0101},
    '{OP_ADC, 24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 4'b1010},
    '{OP_SBB, 24'h000005, 24'h000003, 1'b0, 24'h000001, 4'b1000},
    '{OP_ADD, 24'h000001, 24'h000001, 1'b1, 24'h000002, 4'b0000},
    '{OP_SUB, 24'h123456, 24'h123456, 1'b0, 24'h000000, 4'b1010},
    '{OP_SUB, 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 4'b1100},
    '{OP_ADC, 24'h0000FF, 24'h000000, 1'b1, 24'h000100, 4'b0000},
    '{OP_SBB, 24'h000000, 24'h000000, 1'b1, 24'h000000, 4'b1010}
  };

  adder_pipelined dut (
    .Clock(clk), .Reset(rst), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Op(Op), .CarryIn(CarryIn),
    .OutValid(OutValid), .OutReady(OutReady), .SUM(SUM),
    .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (rst) q.delete();
    else begin
      if (OutValid && OutReady) begin
        if (q.size() == 0) check("pending_results", q.size(), 1);
        else begin
          e = q.pop_front();
          check($sformatf("sum[%0d]", e.i), SUM, tbl[e.i].s);
          check($sformatf("flags[%0d]", e.i), {CarryOut, Overflow, Zero, Negative}, tbl[e.i].f & FM);
          if (nostall) check($sformatf("latency[%0d]", e.i), cyc - e.acc, 3);
        end
      end
      if (InValid && InReady) q.push_back('{cur, cyc});
    end
  end

  task automatic send(input int i);
    cur = i;
    Op = tbl[i].op;
    A = tbl[i].a;
    B = tbl[i].b;
    CarryIn = tbl[i].ci;
    InValid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (InReady) begin
        @(posedge clk);
        #1;
        InValid = 1'b0;
        return;
      end
    end
    check("send_timeout", InReady, 1);
    InValid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 30 && q.size() != 0; t++) @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", OutValid, 0);
    check("rst_sum", SUM, 0);
    check("rst_flags", {CarryOut, Overflow, Zero, Negative}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", InReady, 1);
    @(posedge clk);
    #1;
    send(0);
    drain();
    for (int i = 1; i <= 5; i++) send(i);
    drain();
    nostall = 1'b0;
    OutReady = 1'b0;
    send(6);
    send(7);
    send(8);
    fork
      send(9);
      begin
        for (int t = 0; t < 4; t++) begin
          @(negedge clk);
          check("stall_ready", InReady, 0);
          check("stall_valid", OutValid, 1);
          check("stall_sum", SUM, tbl[6].s);
          check("stall_flags", {CarryOut, Overflow, Zero, Negative}, tbl[6].f & FM);
        end
        @(posedge clk);
        #1;
        OutReady = 1'b1;
      end
    join
    drain();
    nostall = 1'b1;
    send(0);
    send(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", OutValid, 0);
    check("midrst_sum", SUM, 0);
    check("midrst_flags", {CarryOut, Overflow, Zero, Negative}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", InReady, 1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("no_stale", OutValid, 0);
    end
    @(posedge clk);
    #1;
    send(4);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before 100000 time units");
    $fatal(1);
  end
endmodule
